// File: rtl/svm_modality_sched_pkg.sv
`default_nettype none
// svm_modality_sched_pkg: issue-FSM states and sizing helper shared by the SVM front-end scheduler.
// Revision: 1.0
package svm_modality_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_V = 2'd1,
    SEND_A = 2'd2
  } issue_state_t;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/svm_ts_fifo.sv
`default_nettype none
// svm_ts_fifo: synchronous circular FIFO for in-flight sample timestamp entries.
// Revision: 1.0
module svm_ts_fifo
  import svm_modality_sched_pkg::*;
#(
  parameter int DW    = 24,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? ceil_log2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/svm_modality_sched.sv
`default_nettype none
// svm_modality_sched: issues valence then arousal vectors to the SVM, bounds in-flight samples
// and returns each result with its sample ID and valence-issue-to-result latency. Revision: 1.0
module svm_modality_sched
  import svm_modality_sched_pkg::*;
#(
  parameter int NBITS            = 16,
  parameter int F_WIDTH          = 20,
  parameter int MAX_INFLIGHT     = 2,
  parameter int LOG_MAX_INFLIGHT = ceil_log2(MAX_INFLIGHT + 1),
  parameter int ID_W             = 8,
  parameter int CYC_W            = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NBITS*F_WIDTH-1:0]    s_v_features,
  input  logic [NBITS*F_WIDTH-1:0]    s_a_features,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [NBITS*F_WIDTH-1:0]    svm_in_features,
  output logic                        svm_fin_valid,
  input  logic                        svm_fin_ready,
  input  logic                        svm_valence,
  input  logic                        svm_arousal,
  input  logic                        svm_dout_valid,
  output logic                        svm_dout_ready,
  output logic                        r_valence,
  output logic                        r_arousal,
  output logic [ID_W-1:0]             r_id,
  output logic [CYC_W-1:0]            r_latency,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [LOG_MAX_INFLIGHT-1:0] inflight,
  output logic                        err_orphan
);

  localparam int FW = NBITS * F_WIDTH;
  localparam int OW = LOG_MAX_INFLIGHT + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CYC_W-1:0] t_start;
  } ts_entry_t;

  issue_state_t     state;
  issue_state_t     state_n;
  logic [FW-1:0]    v_cap;
  logic [FW-1:0]    a_cap;
  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] t_start;
  logic [ID_W-1:0]  id_ctr;
  ts_entry_t        push_entry;
  ts_entry_t        pop_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pending_push;
  logic [OW-1:0]    occupancy;
  logic             s_hs;
  logic             v_hs;
  logic             push;
  logic             dout_hs;
  logic             pop;

  // A captured sample not yet pushed still reserves an in-flight slot.
  assign pending_push = (state != IDLE);
  assign occupancy    = {1'b0, inflight} + OW'(pending_push);
  assign s_ready      = !rst && (state == IDLE) && (occupancy < OW'(MAX_INFLIGHT));
  assign s_hs         = s_valid && s_ready;
  assign v_hs         = (state == SEND_V) && svm_fin_ready;
  assign push         = (state == SEND_A) && svm_fin_ready && !fifo_full;

  assign svm_dout_ready = !rst && (!r_valid || r_ready);
  assign dout_hs        = svm_dout_valid && svm_dout_ready;
  assign pop            = dout_hs && !fifo_empty;

  assign push_entry = '{id: id_ctr, t_start: t_start};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n         = state;
    svm_fin_valid   = 1'b0;
    svm_in_features = '0;
    case (state)
      IDLE: begin
        if (s_hs) state_n = SEND_V;
      end
      SEND_V: begin
        svm_fin_valid   = 1'b1;
        svm_in_features = v_cap;
        if (svm_fin_ready) state_n = SEND_A;
      end
      SEND_A: begin
        svm_fin_valid   = 1'b1;
        svm_in_features = a_cap;
        if (svm_fin_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc        <= '0;
      t_start    <= '0;
      id_ctr     <= '0;
      v_cap      <= '0;
      a_cap      <= '0;
      r_valid    <= 1'b0;
      r_valence  <= 1'b0;
      r_arousal  <= 1'b0;
      r_id       <= '0;
      r_latency  <= '0;
      err_orphan <= 1'b0;
    end else begin
      cyc <= cyc + CYC_W'(1);
      if (s_hs) begin
        v_cap <= s_v_features;
        a_cap <= s_a_features;
      end
      if (v_hs) t_start <= cyc;
      if (push) id_ctr <= id_ctr + ID_W'(1);
      if (pop) begin
        r_valence <= svm_valence;
        r_arousal <= svm_arousal;
        r_id      <= pop_entry.id;
        r_latency <= cyc - pop_entry.t_start;
        r_valid   <= 1'b1;
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
      // A result with nothing outstanding is swallowed and flagged.
      if (dout_hs && fifo_empty) err_orphan <= 1'b1;
    end
  end

  svm_ts_fifo #(
    .DW   (ID_W + CYC_W),
    .DEPTH(MAX_INFLIGHT),
    .CW   (LOG_MAX_INFLIGHT)
  ) u_ts_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_entry),
    .pop  (pop),
    .dout (pop_entry),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(inflight)
  );

endmodule
`default_nettype wire

// File: tb/tb_svm_modality_sched.sv
`default_nettype none
// Bench for svm_modality_sched: latency vector table, directed corner sequences, randomized run vs. queue model.
module tb_svm_modality_sched;

  localparam int NBITS        = 16;
  localparam int F_WIDTH      = 20;
  localparam int MAX_INFLIGHT = 2;
  localparam int LOGM         = 2;
  localparam int ID_W         = 8;
  localparam int CYC_W        = 16;
  localparam int FW           = NBITS * F_WIDTH;
  localparam int NRAND        = 300;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [FW-1:0]   s_v_features = '0;
  logic [FW-1:0]   s_a_features = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [FW-1:0]   svm_in_features;
  logic            svm_fin_valid;
  logic            svm_fin_ready = 1'b0;
  logic            svm_valence = 1'b0;
  logic            svm_arousal = 1'b0;
  logic            svm_dout_valid = 1'b0;
  logic            svm_dout_ready;
  logic            r_valence;
  logic            r_arousal;
  logic [ID_W-1:0] r_id;
  logic [CYC_W-1:0] r_latency;
  logic            r_valid;
  logic            r_ready = 1'b1;
  logic [LOGM-1:0] inflight;
  logic            err_orphan;

  svm_modality_sched dut (
    .clk(clk), .rst(rst),
    .s_v_features(s_v_features), .s_a_features(s_a_features),
    .s_valid(s_valid), .s_ready(s_ready),
    .svm_in_features(svm_in_features), .svm_fin_valid(svm_fin_valid), .svm_fin_ready(svm_fin_ready),
    .svm_valence(svm_valence), .svm_arousal(svm_arousal),
    .svm_dout_valid(svm_dout_valid), .svm_dout_ready(svm_dout_ready),
    .r_valence(r_valence), .r_arousal(r_arousal), .r_id(r_id), .r_latency(r_latency),
    .r_valid(r_valid), .r_ready(r_ready),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct { logic [FW-1:0] v; logic [FW-1:0] a; } sample_t;
  typedef struct { int id; int t_v; } flight_t;
  typedef struct { logic val; logic ar; int id; int lat; } result_t;
  typedef struct { int v_stall; int a_stall; int ret; int exp_lat; int exp_id; } vec_t;

  sample_t acc_q[$];
  flight_t inf_q[$];
  result_t exp_q[$];
  int      checks = 0;
  int      failures = 0;
  int      edge_n = 0;
  bit      ph = 1'b0;
  int      m_tv = 0;
  int      m_id = 0;
  bit      m_orphan = 1'b0;
  int      rcount = 0;
  int      svm_jobs = 0;
  bit      hs_s, hs_dout;
  int      mon_e;
  flight_t mon_f;
  result_t mon_r;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_vec();
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < FW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model: checks state seen since the last edge, then records handshakes of the coming edge.
  always @(negedge clk) begin
    hs_s    = 1'b0;
    hs_dout = 1'b0;
    if (rst) begin
      acc_q.delete(); inf_q.delete(); exp_q.delete();
      ph = 1'b0; m_id = 0; m_orphan = 1'b0; rcount = 0; svm_jobs = 0;
    end else begin
      mon_e = edge_n + 1;
      chk("fin_valid", FW'(svm_fin_valid), FW'(acc_q.size() != 0));
      if (acc_q.size() != 0) chk("in_features", svm_in_features, ph ? acc_q[0].a : acc_q[0].v);
      chk("s_ready", FW'(s_ready), FW'(acc_q.size() == 0 && inf_q.size() < MAX_INFLIGHT));
      chk("inflight", FW'(inflight), FW'(inf_q.size()));
      chk("dout_ready", FW'(svm_dout_ready), FW'(!r_valid || r_ready));
      chk("r_valid", FW'(r_valid), FW'(exp_q.size() != 0));
      chk("err_orphan", FW'(err_orphan), FW'(m_orphan));
      if (r_valid && r_ready && exp_q.size() != 0) begin
        chk("r_id", FW'(r_id), FW'(exp_q[0].id % 256));
        chk("r_latency", FW'(r_latency), FW'(exp_q[0].lat % 65536));
        chk("r_valence", FW'(r_valence), FW'(exp_q[0].val));
        chk("r_arousal", FW'(r_arousal), FW'(exp_q[0].ar));
        if (rcount == 256) chk("id_wrap", FW'(r_id), '0);
        rcount++;
        void'(exp_q.pop_front());
      end
      if (svm_dout_valid && svm_dout_ready) begin
        hs_dout = 1'b1;
        if (inf_q.size() == 0) m_orphan = 1'b1;
        else begin
          mon_f     = inf_q.pop_front();
          mon_r.val = svm_valence;
          mon_r.ar  = svm_arousal;
          mon_r.id  = mon_f.id;
          mon_r.lat = mon_e - mon_f.t_v;
          exp_q.push_back(mon_r);
          svm_jobs--;
        end
      end
      if (svm_fin_valid && svm_fin_ready && acc_q.size() != 0) begin
        if (!ph) begin
          m_tv = mon_e;
          ph   = 1'b1;
        end else begin
          mon_f.id  = m_id;
          mon_f.t_v = m_tv;
          inf_q.push_back(mon_f);
          m_id++;
          ph = 1'b0;
          void'(acc_q.pop_front());
          svm_jobs++;
        end
      end
      if (s_valid && s_ready) begin
        hs_s = 1'b1;
        acc_q.push_back('{v: s_v_features, a: s_a_features});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sready();
    int n;
    n = 0;
    #1;
    while (!s_ready && n < 100) begin
      tick();
      #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout: actual=0 required=1");
    end
  endtask

  task automatic pulse_reset();
    s_valid = 1'b0; svm_fin_ready = 1'b0; svm_dout_valid = 1'b0; r_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_sample();
    s_v_features = rand_vec();
    s_a_features = rand_vec();
    s_valid = 1'b1;
    wait_sready();
    tick();
    s_valid = 1'b0;
    svm_fin_ready = 1'b1;
    tick();
    tick();
    svm_fin_ready = 1'b0;
  endtask

  task automatic run_one(input vec_t t);
    logic [FW-1:0] vv;
    vv = rand_vec();
    s_v_features = vv;
    s_a_features = rand_vec();
    s_valid = 1'b1;
    wait_sready();
    tick();
    s_valid = 1'b0;
    svm_fin_ready = 1'b0;
    for (int i = 0; i < t.v_stall; i++) begin
      #1;
      chk("stall_valid", FW'(svm_fin_valid), FW'(1));
      chk("stall_data", svm_in_features, vv);
      tick();
    end
    svm_fin_ready = 1'b1;
    tick();
    svm_fin_ready = 1'b0;
    repeat (t.a_stall) tick();
    svm_fin_ready = 1'b1;
    tick();
    svm_fin_ready = 1'b0;
    repeat (t.ret) tick();
    svm_dout_valid = 1'b1;
    svm_valence = 1'($urandom);
    svm_arousal = 1'($urandom);
    tick();
    svm_dout_valid = 1'b0;
    chk("vec_r_valid", FW'(r_valid), FW'(1));
    chk("vec_r_id", FW'(r_id), FW'(t.exp_id));
    chk("vec_r_latency", FW'(r_latency), FW'(t.exp_lat));
    tick();
    chk("vec_inflight_done", FW'(inflight), '0);
  endtask

  vec_t tbl[5];
  int   sent;
  int   ncyc;

  initial begin
    tbl[0] = '{v_stall: 0, a_stall: 0, ret: 10, exp_lat: 12, exp_id: 0};
    tbl[1] = '{v_stall: 5, a_stall: 0, ret: 10, exp_lat: 12, exp_id: 1};
    tbl[2] = '{v_stall: 0, a_stall: 3, ret: 0,  exp_lat: 5,  exp_id: 2};
    tbl[3] = '{v_stall: 2, a_stall: 4, ret: 7,  exp_lat: 13, exp_id: 3};
    tbl[4] = '{v_stall: 0, a_stall: 0, ret: 0,  exp_lat: 2,  exp_id: 4};

    tick();
    tick();
    chk("rst_s_ready", FW'(s_ready), '0);
    chk("rst_fin_valid", FW'(svm_fin_valid), '0);
    chk("rst_features", svm_in_features, '0);
    chk("rst_dout_ready", FW'(svm_dout_ready), '0);
    chk("rst_r_valid", FW'(r_valid), '0);
    chk("rst_labels", FW'({r_valence, r_arousal}), '0);
    chk("rst_r_id", FW'(r_id), '0);
    chk("rst_r_latency", FW'(r_latency), '0);
    chk("rst_inflight", FW'(inflight), '0);
    chk("rst_err_orphan", FW'(err_orphan), '0);
    rst = 1'b0;

    foreach (tbl[i]) run_one(tbl[i]);

    // In-flight limit and release by one returned result.
    pulse_reset();
    send_sample();
    send_sample();
    #1 chk("bp_inflight", FW'(inflight), FW'(2));
    s_v_features = rand_vec();
    s_a_features = rand_vec();
    s_valid = 1'b1;
    #1 chk("bp_block", FW'(s_ready), '0);
    repeat (3) tick();
    chk("bp_hold", FW'(s_ready), '0);
    svm_dout_valid = 1'b1;
    tick();
    svm_dout_valid = 1'b0;
    #1 chk("bp_release", FW'(s_ready), FW'(1));
    chk("bp_first_id", FW'(r_id), '0);
    tick();
    s_valid = 1'b0;
    svm_fin_ready = 1'b1;
    tick();
    tick();
    svm_fin_ready = 1'b0;
    #1 chk("bp_refill", FW'(inflight), FW'(2));

    // Downstream stall holds the second result inside the SVM.
    r_ready = 1'b0;
    svm_dout_valid = 1'b1;
    svm_valence = 1'b1;
    svm_arousal = 1'b0;
    tick();
    chk("hold_r_id", FW'(r_id), FW'(1));
    #1 chk("hold_dout_ready", FW'(svm_dout_ready), '0);
    repeat (2) tick();
    chk("hold_r_id_stable", FW'(r_id), FW'(1));
    chk("hold_inflight", FW'(inflight), FW'(1));
    r_ready = 1'b1;
    tick();
    svm_dout_valid = 1'b0;
    chk("hold_second_valid", FW'(r_valid), FW'(1));
    chk("hold_second_id", FW'(r_id), FW'(2));
    tick();
    chk("hold_drained", FW'(r_valid), '0);

    // Orphan result.
    svm_dout_valid = 1'b1;
    tick();
    svm_dout_valid = 1'b0;
    chk("orphan_set", FW'(err_orphan), FW'(1));
    chk("orphan_no_result", FW'(r_valid), '0);
    chk("orphan_inflight", FW'(inflight), '0);
    repeat (5) tick();
    chk("orphan_sticky", FW'(err_orphan), FW'(1));
    pulse_reset();
    chk("orphan_cleared", FW'(err_orphan), '0);

    // Reset while the arousal vector is being offered.
    s_v_features = rand_vec();
    s_a_features = rand_vec();
    s_valid = 1'b1;
    wait_sready();
    tick();
    s_valid = 1'b0;
    svm_fin_ready = 1'b1;
    tick();
    svm_fin_ready = 1'b0;
    #1 chk("sa_valid", FW'(svm_fin_valid), FW'(1));
    rst = 1'b1;
    tick();
    chk("sa_rst_fin_valid", FW'(svm_fin_valid), '0);
    chk("sa_rst_features", svm_in_features, '0);
    chk("sa_rst_inflight", FW'(inflight), '0);
    chk("sa_rst_r_valid", FW'(r_valid), '0);
    rst = 1'b0;
    run_one('{v_stall: 0, a_stall: 0, ret: 3, exp_lat: 5, exp_id: 0});

    // Randomized traffic; ID wrap is checked by the model at result 256.
    pulse_reset();
    sent = 0;
    ncyc = 0;
    while (rcount < NRAND && ncyc < 20000) begin
      tick();
      ncyc++;
      if (!(s_valid && !hs_s)) begin
        if (sent < NRAND && $urandom_range(0, 3) != 0) begin
          s_v_features = rand_vec();
          s_a_features = rand_vec();
          s_valid = 1'b1;
          sent++;
        end else s_valid = 1'b0;
      end
      svm_fin_ready = ($urandom_range(0, 2) != 0);
      if (!(svm_dout_valid && !hs_dout)) begin
        if (svm_jobs > 0 && $urandom_range(0, 1) != 0) begin
          svm_dout_valid = 1'b1;
          svm_valence = 1'($urandom);
          svm_arousal = 1'($urandom);
        end else svm_dout_valid = 1'b0;
      end
      r_ready = ($urandom_range(0, 3) != 0);
    end
    checks++;
    if (rcount < NRAND) begin
      failures++;
      $display("FAIL random_timeout: actual=%0d required=%0d", rcount, NRAND);
    end
    s_valid = 1'b0;
    svm_dout_valid = 1'b0;
    svm_fin_ready = 1'b0;
    r_ready = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
